mdu_seq: RTL and testbench

Multi-cycle sequencer for the RV32IM M-extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) in the Archer core's execute stage. It latches the operands of an M-type instruction, runs a pipelined multiply or a 1-bit-per-cycle restoring divide, and stalls the core until the result is ready. It resolves RISC-V divide-by-zero and signed-overflow cases without iterating. It hands a registered result back to the writeback mux with a one-cycle done pulse.

---
 rtl/mdu_seq.sv | 150 +++++++++++++++
 tb/tb_mdu_seq.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// RV32IM M-extension sequencer: latches operands, runs a multi-cycle multiply or a
// 1-bit-per-cycle restoring divide, and holds the core in stall until done pulses.
`ifndef XLEN
`define XLEN 32
`endif

module mdu_seq #(
    parameter int MUL_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        funct3,
    input  logic [`XLEN-1:0]  rs1_data,
    input  logic [`XLEN-1:0]  rs2_data,
    output logic              stall,
    output logic              busy,
    output logic              done,
    output logic [`XLEN-1:0]  result
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int CW = (MUL_STAGES > `XLEN) ? $clog2(MUL_STAGES) : $clog2(`XLEN);
    localparam logic [`XLEN-1:0] INT_MIN = {1'b1, {(`XLEN-1){1'b0}}};

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [2:0]       op_q;
    logic [`XLEN-1:0] a_q, b_q, quo_q, rem_q;
    logic             neg_quo_q, neg_rem_q;

    // Operand conditioning for the IDLE latch
    logic             sgn_div_in, div_zero, div_ovf;
    logic [`XLEN-1:0] rs1_abs, rs2_abs;

    always_comb begin
        sgn_div_in = funct3[2] & ~funct3[0];
        rs1_abs    = (sgn_div_in & rs1_data[`XLEN-1]) ? -rs1_data : rs1_data;
        rs2_abs    = (sgn_div_in & rs2_data[`XLEN-1]) ? -rs2_data : rs2_data;
        div_zero   = (rs2_data == '0);
        div_ovf    = sgn_div_in & (rs1_data == INT_MIN) & (rs2_data == '1);
    end

    // 33-bit sign/zero-extended operands; only the low 64 bits of the product are consumed
    logic             a_sgn, b_sgn;
    logic [`XLEN:0]   ea, eb;
    logic [2*`XLEN+1:0] ea_w, eb_w;
    logic [2*`XLEN-1:0] prod;
    logic [`XLEN-1:0] mul_res;

    always_comb begin
        a_sgn   = (op_q != 3'b011);
        b_sgn   = ~op_q[1];
        ea      = {a_sgn & a_q[`XLEN-1], a_q};
        eb      = {b_sgn & b_q[`XLEN-1], b_q};
        ea_w    = {{(`XLEN+1){ea[`XLEN]}}, ea};
        eb_w    = {{(`XLEN+1){eb[`XLEN]}}, eb};
        prod    = (2*`XLEN)'(ea_w * eb_w);
        mul_res = (op_q == 3'b000) ? prod[`XLEN-1:0] : prod[2*`XLEN-1:`XLEN];
    end

    // One restoring-divide step; quo_q shifts the dividend out as quotient bits shift in
    logic [`XLEN:0]   shifted;
    logic             ge;
    logic [`XLEN-1:0] quo_nx, rem_nx, quo_fin, rem_fin;

    always_comb begin
        shifted = {rem_q, quo_q[`XLEN-1]};
        ge      = (shifted >= {1'b0, b_q});
        rem_nx  = ge ? `XLEN'(shifted - {1'b0, b_q}) : shifted[`XLEN-1:0];
        quo_nx  = {quo_q[`XLEN-2:0], ge};
        quo_fin = neg_quo_q ? -quo_nx : quo_nx;
        rem_fin = neg_rem_q ? -rem_nx : rem_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q      <= funct3;
                        a_q       <= rs1_data;
                        b_q       <= funct3[2] ? rs2_abs : rs2_data;
                        quo_q     <= rs1_abs;
                        rem_q     <= '0;
                        neg_quo_q <= sgn_div_in & (rs1_data[`XLEN-1] ^ rs2_data[`XLEN-1]);
                        neg_rem_q <= sgn_div_in & rs1_data[`XLEN-1];
                        if (!funct3[2]) begin
                            state <= S_MUL;
                            cnt   <= CW'(MUL_STAGES - 1);
                        end else if (div_zero) begin
                            state  <= S_DONE;
                            result <= funct3[1] ? rs1_data : '1;
                        end else if (div_ovf) begin
                            state  <= S_DONE;
                            result <= funct3[1] ? '0 : INT_MIN;
                        end else begin
                            state <= S_DIV;
                            cnt   <= CW'(`XLEN - 1);
                        end
                    end
                end
                S_MUL: begin
                    if (!start) begin
                        state <= S_IDLE;
                    end else if (cnt == '0) begin
                        state  <= S_DONE;
                        result <= mul_res;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_DIV: begin
                    if (!start) begin
                        state <= S_IDLE;
                    end else begin
                        quo_q <= quo_nx;
                        rem_q <= rem_nx;
                        if (cnt == '0) begin
                            state  <= S_DONE;
                            result <= op_q[1] ? rem_fin : quo_fin;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign done  = (state == S_DONE);
    assign busy  = (state != S_IDLE);
    assign stall = start & (state != S_DONE);

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: multiply/divide results, latencies, special cases,
// flush, mid-operation reset and back-to-back issue.
`timescale 1ns/1ps

module tb_mdu_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_data, rs2_data;
    logic        stall, busy, done;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

    mdu_seq #(.MUL_STAGES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .stall(stall), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    // Issue one op and count edges until done; bounded at 100 edges
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input bit drop, output int lat, output logic [31:0] res,
                          output int stall_bad);
        @(negedge clk);
        funct3 = f; rs1_data = a; rs2_data = b; start = 1'b1;
        lat = 0; stall_bad = 0;
        while (lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (stall !== ~done) stall_bad++;
            if (done === 1'b1) break;
        end
        res = result;
        if (drop) begin
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; funct3 = '0; rs1_data = '0; rs2_data = '0;
        #12;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", result); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall_lo got=%b exp=0", stall); end
        start = 1'b1; #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL reset_stall_hi got=%b exp=1", stall); end
        @(negedge clk);
        start = 1'b0; rst = 1'b0;
    endtask

    task automatic test_mul();
        int lat, sb; logic [31:0] res;
        run_op(3'b000, 32'd23, 32'd3, 1'b1, lat, res, sb);
        checks++; if (res !== 32'd69) begin errors++; $display("FAIL mul_res got=%h exp=%h", res, 32'd69); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL mul_latency got=%0d exp=3", lat); end
        checks++; if (sb !== 0) begin errors++; $display("FAIL mul_stall got=%0d bad cycles exp=0", sb); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mul_done_pulse got=%b exp=0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mul_idle got=%b exp=0", busy); end
        run_op(3'b001, 32'd23, 32'd3, 1'b1, lat, res, sb);
        checks++; if (res !== 32'h0) begin errors++; $display("FAIL mulh_small got=%h exp=0", res); end
    endtask

    task automatic test_mul_highs();
        logic [2:0]  ops [4] = '{3'b000, 3'b001, 3'b011, 3'b010};
        logic [31:0] exps[4] = '{32'hFFFF8AD0, 32'hFFFFFFFF, 32'h0000752F, 32'h0000752F};
        int lat, sb; logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], 32'd30000, 32'hFFFFFFFF, 1'b1, lat, res, sb);
            checks++;
            if (res !== exps[i]) begin
                errors++; $display("FAIL mul_high_f%0d got=%h exp=%h", ops[i], res, exps[i]);
            end
        end
    endtask

    task automatic test_divide();
        logic [2:0]  ops [6] = '{3'b100, 3'b110, 3'b100, 3'b110, 3'b101, 3'b111};
        logic [31:0] as  [6] = '{32'd23, 32'd23, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd30000, 32'd30000};
        logic [31:0] bs  [6] = '{32'd3, 32'd3, 32'd2, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exps[6] = '{32'd7, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'd0, 32'd30000};
        int lat, sb; logic [31:0] res;
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], as[i], bs[i], 1'b1, lat, res, sb);
            checks++;
            if (res !== exps[i]) begin
                errors++; $display("FAIL div_res_%0d got=%h exp=%h", i, res, exps[i]);
            end
            checks++;
            if (lat !== 33) begin errors++; $display("FAIL div_latency_%0d got=%0d exp=33", i, lat); end
        end
        checks++; if (sb !== 0) begin errors++; $display("FAIL div_stall got=%0d bad cycles exp=0", sb); end
    endtask

    task automatic test_special();
        logic [2:0]  ops [4] = '{3'b100, 3'b110, 3'b100, 3'b110};
        logic [31:0] as  [4] = '{32'd30000, 32'd30000, 32'h80000000, 32'h80000000};
        logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exps[4] = '{32'hFFFFFFFF, 32'd30000, 32'h80000000, 32'd0};
        int lat, sb; logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], bs[i], 1'b1, lat, res, sb);
            checks++;
            if (res !== exps[i]) begin
                errors++; $display("FAIL special_res_%0d got=%h exp=%h", i, res, exps[i]);
            end
            checks++;
            if (lat !== 1) begin errors++; $display("FAIL special_latency_%0d got=%0d exp=1", i, lat); end
        end
    endtask

    task automatic test_abort();
        int lat, sb, seen; logic [31:0] res;
        run_op(3'b000, 32'd23, 32'd3, 1'b1, lat, res, sb);
        @(negedge clk);
        funct3 = 3'b100; rs1_data = 32'd23; rs2_data = 32'd3; start = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before got=%b exp=1", busy); end
        @(negedge clk); start = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle got=%b exp=0", busy); end
        checks++; if (result !== 32'd69) begin errors++; $display("FAIL abort_result got=%h exp=%h", result, 32'd69); end
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (done === 1'b1) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_done got=%0d pulses exp=0", seen); end
    endtask

    task automatic test_reset_mid();
        int lat, sb, seen; logic [31:0] res;
        @(negedge clk);
        funct3 = 3'b100; rs1_data = 32'd23; rs2_data = 32'd3; start = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got=%b exp=1", busy); end
        rst = 1'b1; #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL rstmid_result got=%h exp=0", result); end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (done === 1'b1) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_no_done got=%0d pulses exp=0", seen); end
        run_op(3'b000, 32'd23, 32'd3, 1'b1, lat, res, sb);
        checks++; if (res !== 32'd69) begin errors++; $display("FAIL rstmid_mul_res got=%h exp=%h", res, 32'd69); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL rstmid_mul_latency got=%0d exp=3", lat); end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2, sb1, sb2; logic [31:0] r1, r2;
        run_op(3'b000, 32'd23, 32'd3, 1'b0, lat1, r1, sb1);
        run_op(3'b100, 32'd23, 32'd3, 1'b1, lat2, r2, sb2);
        checks++; if (r1 !== 32'd69) begin errors++; $display("FAIL b2b_mul_res got=%h exp=%h", r1, 32'd69); end
        checks++; if (lat1 !== 3) begin errors++; $display("FAIL b2b_mul_latency got=%0d exp=3", lat1); end
        checks++; if (r2 !== 32'd7) begin errors++; $display("FAIL b2b_div_res got=%h exp=%h", r2, 32'd7); end
        checks++; if (lat2 !== 34) begin errors++; $display("FAIL b2b_div_latency got=%0d exp=34", lat2); end
        checks++; if (sb1 + sb2 !== 0) begin errors++; $display("FAIL b2b_stall got=%0d bad cycles exp=0", sb1 + sb2); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mul_highs();
        test_divide();
        test_special();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
